// File: rtl/zld_fsm.sv
// zld_fsm: zero run-length decoder expanding literal / zero-run tokens into DW-bit samples.
module zld_fsm #(
  parameter int DW = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_v,
  output logic          i_b,
  input  logic [DW:0]   i_d,
  output logic          o_v,
  input  logic          o_b,
  output logic [DW-1:0] o_d,
  output logic          stateo
);
  typedef enum logic {LIT = 1'b0, RUN = 1'b1} state_t;
  state_t        state_q;
  logic [DW-1:0] cnt_q;
  logic [DW-1:0] o_d_q;
  logic          o_v_q;
  logic          can_load;
  assign can_load = !o_v_q || !o_b;
  assign i_b      = reset || (state_q == RUN) || !can_load;
  assign o_v      = o_v_q;
  assign o_d      = o_d_q;
  assign stateo   = state_q;
  // cnt_q counts zeros still owed after the one sitting in the output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= LIT;
      cnt_q   <= '0;
      o_v_q   <= 1'b0;
      o_d_q   <= '0;
    end else if (can_load) begin
      case (state_q)
        LIT: begin
          if (i_v) begin
            o_v_q <= 1'b1;
            o_d_q <= i_d[DW] ? '0 : i_d[DW-1:0];
            if (i_d[DW]) begin
              cnt_q   <= i_d[DW-1:0];
              state_q <= (i_d[DW-1:0] != '0) ? RUN : LIT;
            end
          end else begin
            o_v_q <= 1'b0;
          end
        end
        RUN: begin
          o_v_q <= 1'b1;
          o_d_q <= '0;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == DW'(1)) state_q <= LIT;
        end
        default: begin
          state_q <= state_t'(1'bx);
          cnt_q   <= 'x;
          o_v_q   <= 1'bx;
          o_d_q   <= 'x;
        end
      endcase
    end
  end
endmodule

// File: doc/zld_fsm.md
Name: zld_fsm

Overview:
- Zero run-length decoder, the inverse of the ZLE encoder stage.
- Consumes 8-bit tokens: a literal 7-bit sample, or a zero-run token. Expands each token into 7-bit samples, one per cycle.
- Sits downstream of the encoder, or at the receiving end of a compressed stream.
- Single module holding FSM, run counter and a one-entry registered output; no EOS handling.

Parameters:
- DW, 7, sample width. Token width is DW+1. Run-length field width is DW, so the maximum run is 2^DW.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- i_v  input  1  input token valid
- i_b  output  1  input backpressure; 1 = token not accepted this cycle
- i_d  input  DW+1  input token
- o_v  output  1  output sample valid (registered)
- o_b  input  1  output backpressure from consumer; 1 = stall
- o_d  output  DW  output sample (registered)
- stateo  output  1  current FSM state (0=LIT, 1=RUN), for debug

Behaviour:
- Token format
  - i_d[DW]=0: literal; sample = i_d[DW-1:0].
  - i_d[DW]=1: zero run of length i_d[DW-1:0]+1 (1..2^DW zeros).
  - A literal of value 0 is legal and emits a single 0.
- Transfers
  - Input transfer occurs on a rising edge when i_v=1 and i_b=0.
  - Output transfer occurs when o_v=1 and o_b=0.
- Output register
  - can_load = !o_v || !o_b.
  - When loaded, o_v=1 on the next cycle.
  - When o_v=1 and o_b=1, o_d and o_v hold unchanged.
  - When not loaded and draining, o_v goes to 0.
- Counter: cnt is DW bits and holds zeros remaining after the one currently loaded.
- State LIT
  - i_b = !can_load (combinational).
  - On input transfer with a literal: o_d <= i_d[DW-1:0]; stay in LIT.
  - On input transfer with a run token: o_d <= 0; cnt <= i_d[DW-1:0].
    - If the field is nonzero, go to RUN; otherwise stay in LIT.
- State RUN
  - i_b = 1.
  - When can_load: o_d <= 0 and cnt <= cnt-1.
  - If cnt==1 before the decrement, go to LIT.
- Latency and throughput
  - Token to first sample: 1 cycle.
  - A run of N zeros occupies the output for N consecutive unstalled cycles.
  - i_b is high for N-1 of those cycles.
  - A new token is accepted in the same cycle the last zero of a run is loaded? No: it is accepted on the cycle after entering LIT, so a run token costs N cycles total, with no bubble on o_v.
- Backpressure
  - o_b=1 with o_v=1 freezes state, cnt, o_d and o_v.
  - i_b follows can_load in LIT.
- Reset (asynchronous)
  - state=LIT, cnt=0, o_v=0, o_d=0.
  - i_b=1 while reset is asserted.
  - Reset mid-run discards remaining zeros and any pending output.
- Simultaneous events
  - In LIT, output drain and input transfer in the same cycle load the new sample; o_v stays 1.
- Arithmetic
  - cnt never underflows: RUN is left when cnt reaches 0.
  - Field value 2^DW-1 gives 2^DW zeros; all widths are exact, with no wrap.
- Illegal states: none reachable; the default branch drives outputs to x.

Test Plan:
- Reset, then tokens 0x05, 0x2A, 0x00 with o_b=0 -> o_d=0x05, 0x2A, 0x00 on consecutive cycles, each 1 cycle after acceptance; o_v held 1 throughout; i_b=0.
- Token 0x80 then 0x11 -> o_d=0x00 for 1 cycle then 0x11; stateo stays 0; i_b never 1.
- Token 0x83 then 0x07 -> four 0x00 samples then 0x07; stateo=1 for 3 cycles; i_b=1 during those 3 cycles.
- Token 0xFF -> exactly 128 zeros, then return to LIT.
  - Check cnt boundary: no 129th zero, and no early exit at 127.
- Token 0x84 with o_b raised for 5 cycles after the 2nd zero -> o_d=0, o_v=1 held; stateo=1 held; total of exactly 5 zeros delivered after o_b drops.
- Token 0xFF, assert reset after 10 zeros -> o_v=0 and stateo=0 immediately (async); after release, token 0x03 yields o_d=0x03 with no residual zeros.
